// File: rtl/wb_i2c_txn_sequencer.sv
// ----------------------------------------------------------------------------
// wb_i2c_txn_sequencer
//
// Wishbone master that runs one complete I2C transaction on an iicmb_m_wb
// core for each accepted request. It sequences the core's CSR/DPR/CMDR
// registers through enable, set bus, start, address, data and stop, and
// reports one completion status per transaction.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_*                    request handshake (bus, address, direction, length)
//   wr_valid_i/ready_o/data  write-data stream, one byte per handshake
//   rd_valid_o/rd_data_o     read byte, one-cycle pulse, no backpressure
//   rsp_valid_o/status_o     completion pulse; 00 OK, 01 NAK, 10 AL, 11 error
//   busy_o                   transaction in progress
//   cyc_o .. ack_i           Wishbone master port (CSR=0, DPR=1, CMDR=2)
//   irq_i                    core command-done interrupt
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | ready for a request
// S_CSR_WR   | writing CSR<=0xC0 to enable the core
// S_DPR_WR   | writing DPR (bus index, address byte or write data)
// S_CMD_WR   | writing CMDR with the command for the current phase
// S_IRQ_WAIT | waiting for irq_i, timeout down-counter running
// S_CMD_RD   | reading CMDR to clear irq and decode the command status
// S_WR_GET   | waiting for the next byte on the write stream
// S_DPR_RD   | reading a received byte from DPR
// S_RESP     | one-cycle completion pulse
// ----------------------------------------------------------------------------
module wb_i2c_txn_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int MAX_BYTES      = 16,
    parameter int IRQ_TIMEOUT    = 65535,
    localparam int LEN_W         = $clog2(MAX_BYTES + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [7:0]               req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                     req_rnw_i,
    input  logic [LEN_W-1:0]         req_len_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [7:0]               wr_data_i,
    output logic                     rd_valid_o,
    output logic [7:0]               rd_data_o,
    output logic                     rsp_valid_o,
    output logic [1:0]               rsp_status_o,
    output logic                     busy_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int TMR_W = (IRQ_TIMEOUT > 1) ? $clog2(IRQ_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(IRQ_TIMEOUT);

    localparam logic [WB_ADDR_WIDTH-1:0] REG_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] REG_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] REG_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ_ACK = 8'h02;
    localparam logic [7:0] CMD_READ_NAK = 8'h03;
    localparam logic [7:0] CMD_START    = 8'h04;
    localparam logic [7:0] CMD_STOP     = 8'h05;
    localparam logic [7:0] CMD_SET_BUS  = 8'h06;
    localparam logic [7:0] CSR_ENABLE   = 8'hC0;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAK = 2'b01;
    localparam logic [1:0] ST_AL  = 2'b10;
    localparam logic [1:0] ST_ERR = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_CSR_WR, S_DPR_WR, S_CMD_WR, S_IRQ_WAIT,
        S_CMD_RD, S_WR_GET, S_DPR_RD, S_RESP
    } state_t;

    // Which command the CMD_WR/IRQ_WAIT/CMD_RD loop is currently serving.
    typedef enum logic [2:0] {
        P_BUS, P_START, P_ADDR, P_WDATA, P_RDATA, P_STOP
    } phase_t;

    state_t                     state_q, state_d;
    phase_t                     phase_q, phase_d;
    logic [7:0]                 cmd_q, cmd_d;
    logic [7:0]                 dpr_q, dpr_d;
    logic [7:0]                 bus_q, bus_d;
    logic [I2C_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                       rnw_q, rnw_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           cnt_q, cnt_d;
    logic                       enabled_q, enabled_d;
    logic [7:0]                 last_bus_q, last_bus_d;
    logic [1:0]                 status_q, status_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic                       cyc_q, cyc_d;
    logic                       we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                       rd_valid_q, rd_valid_d;
    logic [7:0]                 rd_data_q, rd_data_d;

    logic                       acc_en;
    logic                       acc_we;
    logic [WB_ADDR_WIDTH-1:0]   acc_adr;
    logic [WB_DATA_WIDTH-1:0]   acc_dat;
    logic                       acc_done;
    logic [LEN_W-1:0]           cnt_inc;

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            phase_q    <= P_BUS;
            cmd_q      <= '0;
            dpr_q      <= '0;
            bus_q      <= '0;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            enabled_q  <= 1'b0;
            last_bus_q <= '0;
            status_q   <= ST_OK;
            timer_q    <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cmd_q      <= cmd_d;
            dpr_q      <= dpr_d;
            bus_q      <= bus_d;
            addr_q     <= addr_d;
            rnw_q      <= rnw_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            enabled_q  <= enabled_d;
            last_bus_q <= last_bus_d;
            status_q   <= status_d;
            timer_q    <= timer_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cmd_d      = cmd_q;
        dpr_d      = dpr_q;
        bus_d      = bus_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        enabled_d  = enabled_q;
        last_bus_d = last_bus_q;
        status_d   = status_q;
        timer_d    = timer_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        acc_en     = 1'b0;
        acc_we     = 1'b0;
        acc_adr    = '0;
        acc_dat    = '0;
        acc_done   = 1'b0;

        // Register access each state issues.
        case (state_q)
            S_CSR_WR: begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = REG_CSR;  acc_dat = WB_DATA_WIDTH'(CSR_ENABLE); end
            S_DPR_WR: begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = REG_DPR;  acc_dat = WB_DATA_WIDTH'(dpr_q); end
            S_CMD_WR: begin acc_en = 1'b1; acc_we = 1'b1; acc_adr = REG_CMDR; acc_dat = WB_DATA_WIDTH'(cmd_q); end
            S_CMD_RD: begin acc_en = 1'b1; acc_adr = REG_CMDR; end
            S_DPR_RD: begin acc_en = 1'b1; acc_adr = REG_DPR; end
            default:  ;
        endcase

        // Outputs are registered: an access starts the cycle after the state
        // is entered, so each access is preceded by at least one idle cycle.
        if (acc_en) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                we_d  = acc_we;
                adr_d = acc_adr;
                dat_d = acc_dat;
            end else if (ack_i) begin
                cyc_d    = 1'b0;
                we_d     = 1'b0;
                adr_d    = '0;
                dat_d    = '0;
                acc_done = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    bus_d    = req_bus_i;
                    addr_d   = req_addr_i;
                    rnw_d    = req_rnw_i;
                    len_d    = (int'(req_len_i) > MAX_BYTES) ? LEN_W'(MAX_BYTES) : req_len_i;
                    cnt_d    = '0;
                    status_d = ST_OK;
                    if (int'(req_bus_i) >= NUM_I2C_BUSSES) begin
                        status_d = ST_ERR;
                        state_d  = S_RESP;
                    end else if (!enabled_q) begin
                        state_d = S_CSR_WR;
                    end else if (req_bus_i == last_bus_q) begin
                        cmd_d   = CMD_START;
                        phase_d = P_START;
                        state_d = S_CMD_WR;
                    end else begin
                        dpr_d   = req_bus_i;
                        phase_d = P_BUS;
                        state_d = S_DPR_WR;
                    end
                end
            end
            S_CSR_WR: begin
                if (acc_done) begin
                    enabled_d = 1'b1;
                    dpr_d     = bus_q;
                    phase_d   = P_BUS;
                    state_d   = S_DPR_WR;
                end
            end
            S_DPR_WR: begin
                if (acc_done) begin
                    cmd_d   = (phase_q == P_BUS) ? CMD_SET_BUS : CMD_WRITE;
                    state_d = S_CMD_WR;
                end
            end
            S_CMD_WR: begin
                if (acc_done) begin
                    timer_d = TMR_LOAD;
                    state_d = S_IRQ_WAIT;
                end
            end
            S_IRQ_WAIT: begin
                if (irq_i) begin
                    state_d = S_CMD_RD;
                end else if (IRQ_TIMEOUT != 0) begin
                    if (timer_q == '0) begin
                        // Core state is unknown after a hang; force a re-enable.
                        enabled_d = 1'b0;
                        status_d  = ST_ERR;
                        state_d   = S_RESP;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            S_CMD_RD: begin
                if (acc_done) begin
                    if (dat_i[5]) begin
                        // Bus lost: the core no longer owns the bus, no STOP.
                        status_d = ST_AL;
                        state_d  = S_RESP;
                    end else if (phase_q == P_STOP) begin
                        if ((dat_i[4] || !dat_i[7]) && status_q == ST_OK)
                            status_d = ST_ERR;
                        state_d = S_RESP;
                    end else if (dat_i[4] || !dat_i[7] || dat_i[6]) begin
                        status_d = (dat_i[4] || !dat_i[7]) ? ST_ERR : ST_NAK;
                        cmd_d    = CMD_STOP;
                        phase_d  = P_STOP;
                        state_d  = S_CMD_WR;
                    end else begin
                        case (phase_q)
                            P_BUS: begin
                                last_bus_d = bus_q;
                                cmd_d      = CMD_START;
                                phase_d    = P_START;
                                state_d    = S_CMD_WR;
                            end
                            P_START: begin
                                dpr_d   = 8'({addr_q, rnw_q});
                                phase_d = P_ADDR;
                                state_d = S_DPR_WR;
                            end
                            P_ADDR: begin
                                if (len_q == '0) begin
                                    cmd_d   = CMD_STOP;
                                    phase_d = P_STOP;
                                    state_d = S_CMD_WR;
                                end else if (rnw_q) begin
                                    cmd_d   = (len_q == LEN_W'(1)) ? CMD_READ_NAK : CMD_READ_ACK;
                                    phase_d = P_RDATA;
                                    state_d = S_CMD_WR;
                                end else begin
                                    phase_d = P_WDATA;
                                    state_d = S_WR_GET;
                                end
                            end
                            P_WDATA: begin
                                cnt_d = cnt_inc;
                                if (cnt_inc == len_q) begin
                                    cmd_d   = CMD_STOP;
                                    phase_d = P_STOP;
                                    state_d = S_CMD_WR;
                                end else begin
                                    state_d = S_WR_GET;
                                end
                            end
                            P_RDATA: state_d = S_DPR_RD;
                            default: state_d = S_RESP;
                        endcase
                    end
                end
            end
            S_WR_GET: begin
                if (wr_valid_i) begin
                    dpr_d   = wr_data_i;
                    state_d = S_DPR_WR;
                end
            end
            S_DPR_RD: begin
                if (acc_done) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = dat_i[7:0];
                    cnt_d      = cnt_inc;
                    if (cnt_inc == len_q) begin
                        cmd_d   = CMD_STOP;
                        phase_d = P_STOP;
                    end else begin
                        // Final byte of a read is NAKed to release the slave.
                        cmd_d   = (cnt_inc == len_q - LEN_W'(1)) ? CMD_READ_NAK : CMD_READ_ACK;
                        phase_d = P_RDATA;
                    end
                    state_d = S_CMD_WR;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign wr_ready_o   = (state_q == S_WR_GET);
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_status_o = status_q;
    assign busy_o       = (state_q != S_IDLE);
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;

endmodule
